memory_param: RTL and testbench
===============================

// Module: memory_param
// PURPOSE
//   Parametrised single-port synchronous memory for the ALU/memory/comparator datapath.
//   Generalises the fixed 8-bit memory to WIDTH x DEPTH, with three additions:
//   - a valid/ready request interface;
//   - a registered read port;
//   - a hardware zero-fill sweep that runs after reset and on request.
//   Sits between the ALU result bus and the comparator operand fetch.
// PARAMETERS
//   WIDTH  8   data word width in bits (>=1)
//   DEPTH  16  number of words (>=2, need not be a power of two)
//   AW     derived localparam = $clog2(DEPTH), address width
// PORTS
//   clk        in   1      rising-edge clock, sole clock domain
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      request zero-fill sweep of the whole array
//   req_valid  in   1      request present
//   req_ready  out  1      request can be accepted this cycle
//   req_we     in   1      1 = write, 0 = read
//   req_addr   in   AW     word address
//   req_wdata  in   WIDTH  write data
//   rd_valid   out  1      one-cycle pulse: rd_data/rd_err valid
//   rd_data    out  WIDTH  read data, held until the next rd_valid
//   rd_err     out  1      read address was >= DEPTH (qualified by rd_valid)
//   busy       out  1      zero-fill sweep in progress
// BEHAVIOUR
//   Reset (rst_n=0, async)
//     - state=SWEEP, sweep counter=0.
//     - rd_valid=0, rd_data=0, rd_err=0, busy=1, req_ready=0.
//     - Array contents are undefined until the sweep completes.
//   FSM states: SWEEP, IDLE.
//     - SWEEP: each cycle mem[cnt]<=0 and cnt++. At cnt==DEPTH-1, write it and go to IDLE.
//       Exactly DEPTH cycles. busy=1, req_ready=0 throughout.
//     - IDLE: busy=0. clear=1 -> SWEEP with cnt=0 on the next edge.
//   req_ready = (state==IDLE) && !clear, combinational.
//     - clear has priority over a simultaneous request; that request is not accepted.
//   Handshake
//     - A request is accepted on the rising edge where req_valid && req_ready.
//     - The master holds all req_* stable while req_valid=1 && req_ready=0.
//     - One request per cycle; back-to-back accepts are allowed.
//   Write (req_we=1)
//     - mem[req_addr] <= req_wdata at the accept edge. No rd_valid.
//     - req_addr >= DEPTH: the write is dropped silently.
//   Read (req_we=0)
//     - Latency 1: rd_valid=1 in the cycle after the accept edge.
//     - rd_data is registered and updates only with rd_valid.
//     - req_addr >= DEPTH: rd_data=0, rd_err=1. Otherwise rd_err=0.
//     - A read one cycle after a write to the same address returns the new data.
//   clear in SWEEP restarts the sweep at cnt=0.
//   Reset asserted mid-sweep or mid-read
//     - Aborts immediately; a pending rd_valid is lost.
//     - The sweep restarts after rst_n rises.
//   rd_valid=0 in every cycle without a read accept on the previous edge, including during SWEEP.
// TESTING
//   1. Release rst_n; count cycles.
//      -> busy=1 for exactly DEPTH=16 cycles, then req_ready=1.
//      -> A read of every address returns 0x00 with rd_err=0.
//   2. Write 0xA5 @3, then read @3 on the next cycle.
//      -> rd_valid one cycle after the read accept; rd_data=0xA5.
//   3. Back-to-back reads @0..@15 after writes of data=addr.
//      -> 16 consecutive rd_valid pulses with rd_data 0..15 in order.
//   4. DEPTH=10: write 0xFF @12, then read @12.
//      -> rd_err=1, rd_data=0x00.
//      -> Reads @0..@9 remain unaffected.
//   5. Assert clear together with req_valid (write 0x11 @5).
//      -> req_ready=0; write not accepted.
//      -> busy for 16 cycles, then read @5 returns 0x00.
//   6. Pulse rst_n low on sweep cycle 7.
//      -> After release, outputs take reset values and busy lasts a full 16 cycles.
//   7. Run case 1 with WIDTH=32 and DEPTH=64.

Source files
------------

// File: rtl/memory_param_if.sv
// Request/response bundle for memory_param: valid/ready request channel plus registered read return.
interface memory_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/memory_param.sv
// WIDTH x DEPTH single-port memory with valid/ready requests, registered read port
// and a zero-fill sweep that runs out of reset and whenever clear is raised.
module memory_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    memory_param_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic addr_ok;
    logic accept;

    // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
    assign addr_ok       = 32'(bus.req_addr) < DEPTH;
    assign bus.req_ready = (state_q == ST_IDLE) && !clear;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        rd_err_d   = rd_err_q;
        rd_data_d  = rd_data_q;
        mem_we     = 1'b0;
        mem_waddr  = cnt_q;
        mem_wdata  = '0;

        unique case (state_q)
            ST_SWEEP: begin
                mem_we = 1'b1;
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (bus.req_we) begin
                        mem_we    = addr_ok;
                        mem_waddr = bus.req_addr;
                        mem_wdata = bus.req_wdata;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_err_d   = !addr_ok;
                        rd_data_d  = addr_ok ? mem[bus.req_addr] : '0;
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_SWEEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SWEEP;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array is not reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_data  = rd_data_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_memory_param.sv
// Self-checking bench for memory_param: three instances (8x16, 8x10, 32x64) against a sweep/array model.
module tb_memory_param;
    localparam int NDUT = 3;
    localparam int DEP [NDUT] = '{16, 10, 64};
    localparam int WID [NDUT] = '{8, 8, 32};
    localparam int AWS [NDUT] = '{4, 4, 6};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear [NDUT];
    logic        valid [NDUT];
    logic        we    [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic        busy_o [NDUT];
    logic        rdy_o  [NDUT];
    logic        rv_o   [NDUT];
    logic        err_o  [NDUT];
    logic [31:0] rd_o   [NDUT];

    memory_param_if #(.WIDTH(8),  .DEPTH(16)) if0 ();
    memory_param_if #(.WIDTH(8),  .DEPTH(10)) if1 ();
    memory_param_if #(.WIDTH(32), .DEPTH(64)) if2 ();

    assign if0.req_valid = valid[0];
    assign if0.req_we    = we[0];
    assign if0.req_addr  = addr[0][3:0];
    assign if0.req_wdata = wdata[0][7:0];
    assign rdy_o[0]      = if0.req_ready;
    assign rv_o[0]       = if0.rd_valid;
    assign err_o[0]      = if0.rd_err;
    assign rd_o[0]       = {24'h0, if0.rd_data};

    assign if1.req_valid = valid[1];
    assign if1.req_we    = we[1];
    assign if1.req_addr  = addr[1][3:0];
    assign if1.req_wdata = wdata[1][7:0];
    assign rdy_o[1]      = if1.req_ready;
    assign rv_o[1]       = if1.rd_valid;
    assign err_o[1]      = if1.rd_err;
    assign rd_o[1]       = {24'h0, if1.rd_data};

    assign if2.req_valid = valid[2];
    assign if2.req_we    = we[2];
    assign if2.req_addr  = addr[2][5:0];
    assign if2.req_wdata = wdata[2];
    assign rdy_o[2]      = if2.req_ready;
    assign rv_o[2]       = if2.rd_valid;
    assign err_o[2]      = if2.rd_err;
    assign rd_o[2]       = if2.rd_data;

    memory_param #(.WIDTH(8), .DEPTH(16)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .busy(busy_o[0]), .bus(if0.slave));
    memory_param #(.WIDTH(8), .DEPTH(10)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .busy(busy_o[1]), .bus(if1.slave));
    memory_param #(.WIDTH(32), .DEPTH(64)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]), .busy(busy_o[2]), .bus(if2.slave));

    // Reference: remaining sweep cycles per instance, a plain word array, and the last read result.
    int          sweep_left [NDUT];
    logic [31:0] mm [NDUT][64];
    logic        m_rv  [NDUT];
    logic        m_err [NDUT];
    logic        m_acc [NDUT];
    logic [31:0] m_rd  [NDUT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] msk(input int k);
        return (WID[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WID[k]) - 32'd1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            sweep_left[k] = DEP[k];
            m_rv[k]  = 1'b0;
            m_err[k] = 1'b0;
            m_acc[k] = 1'b0;
            m_rd[k]  = 32'h0;
            for (int a = 0; a < 64; a++) mm[k][a] = 32'h0;
        end
    endtask

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NDUT; k++) begin
            int  a;
            logic rdy;
            a   = int'(addr[k]);
            rdy = (sweep_left[k] == 0) && !clear[k];
            m_acc[k] = valid[k] && rdy;
            m_rv[k]  = 1'b0;
            if (m_acc[k] && !we[k]) begin
                m_rv[k]  = 1'b1;
                m_err[k] = (a >= DEP[k]);
                m_rd[k]  = (a >= DEP[k]) ? 32'h0 : mm[k][a];
            end
            if (m_acc[k] && we[k] && a < DEP[k]) mm[k][a] = wdata[k] & msk(k);
            if (clear[k]) begin
                sweep_left[k] = DEP[k];
                for (int j = 0; j < 64; j++) mm[k][j] = 32'h0;
            end else if (sweep_left[k] > 0) begin
                sweep_left[k]--;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            chkb($sformatf("busy%0d", k), busy_o[k], sweep_left[k] > 0);
            chkb($sformatf("ready%0d", k), rdy_o[k], (sweep_left[k] == 0) && !clear[k]);
            chkb($sformatf("rd_valid%0d", k), rv_o[k], m_rv[k]);
            chk($sformatf("rd_data%0d", k), rd_o[k], m_rd[k]);
            if (m_rv[k]) chkb($sformatf("rd_err%0d", k), err_o[k], m_err[k]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_all();
        for (int k = 0; k < NDUT; k++) begin
            valid[k] = 1'b0;
            clear[k] = 1'b0;
        end
    endtask

    initial begin
        vec_t tbl [$];
        int   len [NDUT];
        int   n;

        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            clear[k] = 1'b0; valid[k] = 1'b0; we[k] = 1'b0;
            addr[k] = 32'h0; wdata[k] = 32'h0; len[k] = 0;
        end
        model_reset();
        repeat (3) tick();

        // Sweep length after reset release, then every address reads back zero.
        rst_n = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            for (int k = 0; k < NDUT; k++)
                if (len[k] == 0 && !busy_o[k]) len[k] = c;
        end
        for (int k = 0; k < NDUT; k++) chk($sformatf("busy_len%0d", k), 32'(len[k]), 32'(DEP[k]));

        for (int a = 0; a < 64; a++) begin
            for (int k = 0; k < NDUT; k++) begin
                valid[k] = (a < DEP[k]); we[k] = 1'b0; addr[k] = 32'(a);
            end
            tick();
            for (int k = 0; k < NDUT; k++)
                if (a < DEP[k]) chk($sformatf("zero%0d_@%0d", k, a), rd_o[k], 32'h0);
        end
        idle_all();
        tick();

        // Directed vectors: read-after-write, out-of-range on DEPTH=10, wide word.
        tbl.push_back('{0, 1'b1, 32'd3,  32'hA5,       32'h0,        1'b0});
        tbl.push_back('{0, 1'b0, 32'd3,  32'h0,        32'hA5,       1'b0});
        tbl.push_back('{1, 1'b1, 32'd12, 32'hFF,       32'h0,        1'b0});
        tbl.push_back('{1, 1'b0, 32'd12, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1, 1'b0, 32'd9,  32'h0,        32'h0,        1'b0});
        tbl.push_back('{2, 1'b1, 32'd63, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{2, 1'b0, 32'd63, 32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 1'b1, 32'd15, 32'h7E,       32'h0,        1'b0});
        tbl.push_back('{0, 1'b0, 32'd15, 32'h0,        32'h7E,       1'b0});
        tbl.push_back('{1, 1'b0, 32'd15, 32'h0,        32'h0,        1'b1});
        foreach (tbl[i]) begin
            idle_all();
            valid[tbl[i].k] = 1'b1;
            we[tbl[i].k]    = tbl[i].we;
            addr[tbl[i].k]  = tbl[i].addr;
            wdata[tbl[i].k] = tbl[i].wdata;
            tick();
            chkb($sformatf("vec%0d_rv", i), rv_o[tbl[i].k], !tbl[i].we);
            if (!tbl[i].we) begin
                chk($sformatf("vec%0d_data", i), rd_o[tbl[i].k], tbl[i].exp_rd);
                chkb($sformatf("vec%0d_err", i), err_o[tbl[i].k], tbl[i].exp_err);
            end
        end
        idle_all();
        tick();

        for (int a = 0; a < 10; a++) begin
            valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'(a);
            tick();
            chk($sformatf("d10_@%0d", a), rd_o[1], 32'h0);
            chkb($sformatf("d10_err@%0d", a), err_o[1], 1'b0);
        end
        idle_all();

        // Back-to-back writes data=addr, then 16 consecutive reads.
        for (int a = 0; a < 16; a++) begin
            valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'(a); wdata[0] = 32'(a);
            tick();
        end
        for (int a = 0; a < 16; a++) begin
            valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'(a);
            tick();
            chkb($sformatf("b2b_rv%0d", a), rv_o[0], 1'b1);
            chk($sformatf("b2b_data%0d", a), rd_o[0], 32'(a));
        end
        idle_all();
        tick();
        chkb("b2b_rv_end", rv_o[0], 1'b0);

        // clear wins over a simultaneous write.
        valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd5; wdata[0] = 32'h11; clear[0] = 1'b1;
        #1;
        chkb("clear_ready", rdy_o[0], 1'b0);
        tick();
        idle_all();
        n = 0;
        while (busy_o[0] && n < 100) begin
            tick();
            n++;
        end
        chk("clear_busy_len", 32'(n), 32'd16);
        valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd5;
        tick();
        chk("clear_rd5", rd_o[0], 32'h0);

        // Reset right after a read accept drops the pending rd_valid.
        tick();
        idle_all();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chkb("rst_rv_lost", rv_o[0], 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (busy_o[0] && n < 100) begin
            tick();
            n++;
        end
        chk("rst_mid_sweep_len", 32'(n), 32'd16);
        repeat (50) tick();

        // Randomised traffic with occasional clears; stalled requests are held stable.
        for (int it = 0; it < 600; it++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (!(valid[k] && !m_acc[k])) begin
                    valid[k] = ($urandom_range(0, 9) < 7);
                    we[k]    = 1'($urandom_range(0, 1));
                    addr[k]  = 32'($urandom_range(0, (1 << AWS[k]) - 1));
                    wdata[k] = $urandom;
                end
                clear[k] = ($urandom_range(0, 199) == 0);
            end
            tick();
        end
        idle_all();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
